// File: rtl/mem_align_pkg.sv
// Shared opcodes, funct3 encodings, FSM states and access-decode helpers for the
// load/store alignment unit.
package mem_align_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LD  = 3'b011;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;
  localparam logic [2:0] FNC_LWU = 3'b110;

  localparam logic [2:0] FNC_SB = 3'b000;
  localparam logic [2:0] FNC_SH = 3'b001;
  localparam logic [2:0] FNC_SW = 3'b010;
  localparam logic [2:0] FNC_SD = 3'b011;

  typedef enum logic [2:0] {
    StIdle,
    StIssue0,
    StWait0,
    StIssue1,
    StWait1,
    StResp
  } state_e;

  // funct3[1:0] encodes log2 of the access size for both loads and stores.
  function automatic int unsigned size_bytes(input logic [2:0] funct3);
    return 32'd1 << funct3[1:0];
  endfunction

  function automatic logic access_legal(input logic [6:0] opcode, input logic [2:0] funct3,
                                        input logic wide);
    logic ok;
    ok = 1'b0;
    if (opcode == OPC_LOAD) begin
      case (funct3)
        FNC_LB, FNC_LH, FNC_LW, FNC_LBU, FNC_LHU: ok = 1'b1;
        FNC_LD, FNC_LWU:                          ok = wide;
        default:                                  ok = 1'b0;
      endcase
    end else if (opcode == OPC_STORE) begin
      case (funct3)
        FNC_SB, FNC_SH, FNC_SW: ok = 1'b1;
        FNC_SD:                 ok = wide;
        default:                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/mem_align_unit_lane_shifter.sv
// Combinational byte-lane steering: store mask/data per beat and extended load result
// assembled from two read beats.
module mem_lane_shifter
  import mem_align_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]                   funct3_i,
  input  logic [$clog2(XLEN/8)-1:0]    off_i,
  input  logic                         beat_sel_i,
  input  logic [XLEN-1:0]              wdata_i,
  input  logic [XLEN-1:0]              beat0_i,
  input  logic [XLEN-1:0]              beat1_i,
  output logic [XLEN/8-1:0]            wmask_o,
  output logic [XLEN-1:0]              wdata_o,
  output logic [XLEN-1:0]              rdata_o
);

  localparam int unsigned NumBytes = XLEN / 8;

  int unsigned        size;
  logic [2*NumBytes-1:0] mask_wide;
  logic [2*XLEN-1:0]  data_wide;
  logic [2*XLEN-1:0]  rd_wide;
  logic [XLEN-1:0]    rd_raw;
  logic               sign;

  always_comb begin
    size      = size_bytes(funct3_i);
    mask_wide = '0;
    for (int i = 0; i < int'(NumBytes); i++) begin
      if (i < int'(size)) mask_wide[i] = 1'b1;
    end
    // Double-width shifts: the upper half is exactly what spills into beat 1.
    mask_wide = mask_wide << off_i;
    data_wide = {{XLEN{1'b0}}, wdata_i} << (8 * off_i);
    wmask_o   = beat_sel_i ? mask_wide[2*NumBytes-1:NumBytes] : mask_wide[NumBytes-1:0];
    wdata_o   = beat_sel_i ? data_wide[2*XLEN-1:XLEN] : data_wide[XLEN-1:0];

    rd_wide = {beat1_i, beat0_i} >> (8 * off_i);
    rd_raw  = rd_wide[XLEN-1:0];
    sign    = 1'b0;
    rdata_o = '0;
    for (int b = 0; b < int'(NumBytes); b++) begin
      if (b < int'(size)) begin
        rdata_o[8*b +: 8] = rd_raw[8*b +: 8];
        if (b + 1 == int'(size)) sign = rd_raw[8*b+7] & ~funct3_i[2];
      end else begin
        rdata_o[8*b +: 8] = {8{sign}};
      end
    end
  end

endmodule

// File: rtl/mem_align_unit.sv
// Load/store alignment unit: captures one request, issues one or two word-aligned
// memory beats, and returns a single-cycle completion with the extended load data.
module mem_align_unit
  import mem_align_pkg::*;
#(
  parameter int unsigned XLEN             = 32,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [6:0]        req_opcode_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [31:0]       req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [31:0]       mem_addr_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_wmask_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              resp_valid_o,
  output logic [XLEN-1:0]   resp_rdata_o,
  output logic              resp_err_o
);

  localparam int unsigned NumBytes = XLEN / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam bit          Wide     = (XLEN == 64);

  state_e            state_q, state_d;
  logic              store_q, store_d;
  logic              err_q, err_d;
  logic              split_q, split_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   beat0_q, beat0_d;
  logic [XLEN-1:0]   beat1_q, beat1_d;

  logic [OffW-1:0]   req_off;
  int unsigned       req_size;
  logic              req_split;
  logic              req_err;

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    err_d    = err_q;
    split_d  = split_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    beat0_d  = beat0_q;
    beat1_d  = beat1_q;

    req_off   = req_addr_i[OffW-1:0];
    req_size  = size_bytes(req_funct3_i);
    req_split = (32'(req_off) + req_size) > NumBytes;
    req_err   = !access_legal(req_opcode_i, req_funct3_i, Wide) ||
                (req_split && !ALLOW_MISALIGNED);

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          store_d  = (req_opcode_i == OPC_STORE);
          err_d    = req_err;
          split_d  = req_split;
          funct3_d = req_funct3_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          beat0_d  = '0;
          beat1_d  = '0;
          state_d  = req_err ? StResp : StIssue0;
        end
      end
      StIssue0: begin
        if (mem_req_ready_i) begin
          if (!store_q)     state_d = StWait0;
          else if (split_q) state_d = StIssue1;
          else              state_d = StResp;
        end
      end
      StWait0: begin
        if (mem_rvalid_i) begin
          beat0_d = mem_rdata_i;
          state_d = split_q ? StIssue1 : StResp;
        end
      end
      StIssue1: begin
        if (mem_req_ready_i) state_d = store_q ? StResp : StWait1;
      end
      StWait1: begin
        if (mem_rvalid_i) begin
          beat1_d = mem_rdata_i;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      store_q  <= 1'b0;
      err_q    <= 1'b0;
      split_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      beat0_q  <= '0;
      beat1_q  <= '0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      err_q    <= err_d;
      split_q  <= split_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      beat0_q  <= beat0_d;
      beat1_q  <= beat1_d;
    end
  end

  logic                issue;
  logic                beat_sel;
  logic [31:0]         base_addr;
  logic [NumBytes-1:0] lane_wmask;
  logic [XLEN-1:0]     lane_wdata;
  logic [XLEN-1:0]     lane_rdata;

  mem_lane_shifter #(
    .XLEN (XLEN)
  ) u_lane_shifter (
    .funct3_i   (funct3_q),
    .off_i      (addr_q[OffW-1:0]),
    .beat_sel_i (beat_sel),
    .wdata_i    (wdata_q),
    .beat0_i    (beat0_q),
    .beat1_i    (beat1_q),
    .wmask_o    (lane_wmask),
    .wdata_o    (lane_wdata),
    .rdata_o    (lane_rdata)
  );

  assign issue     = (state_q == StIssue0) || (state_q == StIssue1);
  assign beat_sel  = (state_q == StIssue1);
  assign base_addr = addr_q & ~32'(NumBytes - 1);

  assign req_ready_o     = (state_q == StIdle);
  assign mem_req_valid_o = issue;
  // Beat-1 address wraps naturally in 32-bit arithmetic.
  assign mem_addr_o      = issue ? base_addr + (beat_sel ? 32'(NumBytes) : 32'd0) : '0;
  assign mem_we_o        = issue & store_q;
  assign mem_wmask_o     = (issue & store_q) ? lane_wmask : '0;
  assign mem_wdata_o     = (issue & store_q) ? lane_wdata : '0;
  assign resp_valid_o    = (state_q == StResp);
  assign resp_err_o      = resp_valid_o & err_q;
  assign resp_rdata_o    = (resp_valid_o && !store_q && !err_q) ? lane_rdata : '0;

endmodule
